// File: rtl/wgt_pkg.sv
// Shared constants, state encoding and helpers for the weight feeder.
package wgt_pkg;

  localparam int unsigned DATA_WID = 16;
  localparam int unsigned SIZE     = 8;
  localparam int unsigned ADDR_WID = 5;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned WORD_WID = SIZE * DATA_WID;
  localparam int unsigned KS_WID   = 3;
  localparam int unsigned VN_WID   = 4;
  localparam int unsigned FIFO_D   = RD_LAT + 1;

  localparam logic [KS_WID-1:0] KSIZE_1 = 3'd1;
  localparam logic [KS_WID-1:0] KSIZE_3 = 3'd3;
  localparam logic [KS_WID-1:0] KSIZE_5 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

  function automatic logic ksize_legal(input logic [KS_WID-1:0] k);
    return (k == KSIZE_1) || (k == KSIZE_3) || (k == KSIZE_5);
  endfunction

  function automatic logic [ADDR_WID-1:0] ksize_sq(input logic [KS_WID-1:0] k);
    return ADDR_WID'(k) * ADDR_WID'(k);
  endfunction

endpackage

// File: rtl/skew_line.sv
// Per-lane delay line of DEPTH registers with a shared hold enable; valid travels with data.
module skew_line #(
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned DEPTH    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [DATA_WID-1:0] data_i,
  input  logic                valid_i,
  output logic [DATA_WID-1:0] data_o,
  output logic                valid_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_i, en_i};
    assign data_o    = data_i;
    assign valid_o   = valid_i;
  end else begin : g_dly
    logic [DATA_WID-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]    valid_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= '0;
        for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      end else if (en_i) begin
        data_q[0]  <= data_i;
        valid_q[0] <= valid_i;
        for (int k = 1; k < DEPTH; k++) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/wgt_feeder.sv
// Reads the column-ordered kernel buffer and streams it, diagonally skewed, into the array
// with credit-based read issue so the return FIFO can never overflow under back-pressure.
module wgt_feeder
  import wgt_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                feed_start_i,
  input  logic [KS_WID-1:0]   kernel_size_i,
  input  logic [VN_WID-1:0]   valid_num_i,
  output logic                feed_ready_o,
  output logic                feed_done_o,
  output logic                feed_err_o,
  output logic [ADDR_WID-1:0] buf_rd_addr_o,
  output logic                buf_rd_en_o,
  input  logic [WORD_WID-1:0] buf_rd_data_i,
  input  logic                arr_stall_i,
  output logic [WORD_WID-1:0] arr_wgt_o,
  output logic [SIZE-1:0]     arr_wgt_valid_o
);

  localparam int unsigned PTR_WID = $clog2(FIFO_D);
  localparam int unsigned CNT_WID = $clog2(FIFO_D + 1);
  localparam int unsigned SUM_WID = CNT_WID + 2;

  feed_state_e         state_q, state_d;
  logic [ADDR_WID-1:0] n_words_q, n_words_d;
  logic [ADDR_WID-1:0] issue_q, issue_d;
  logic [VN_WID-1:0]   vnum_q, vnum_d;
  logic [ADDR_WID-1:0] rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [RD_LAT-1:0]   ret_pipe_q, ret_pipe_d;
  logic [WORD_WID-1:0] fifo_mem_q [FIFO_D];
  logic [PTR_WID-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WID-1:0]  count_q, count_d;
  logic [SIZE-1:0]     tok_q, tok_d;
  logic [WORD_WID-1:0] stage0_data_q, stage0_data_d;
  logic [SIZE-1:0]     stage0_vld_q, stage0_vld_d;

  logic                ret_valid_c, fifo_empty_c, pop_c, push_c, fifo_pop_c, shift_en_c;
  logic                credit_ok_c, drained_c;
  logic [WORD_WID-1:0] pop_data_c;
  logic [SUM_WID-1:0]  inflight_c;

  // Return FIFO with bypass: an empty FIFO hands returning data straight to stage 0.
  always_comb begin
    ret_valid_c  = ret_pipe_q[RD_LAT-1];
    fifo_empty_c = (count_q == '0);
    shift_en_c   = !arr_stall_i;
    pop_c        = shift_en_c && (!fifo_empty_c || ret_valid_c);
    fifo_pop_c   = shift_en_c && !fifo_empty_c;
    push_c       = ret_valid_c && !(fifo_empty_c && shift_en_c);
    pop_data_c   = fifo_empty_c ? buf_rd_data_i : fifo_mem_q[rd_ptr_q];
    count_d      = count_q + CNT_WID'(push_c) - CNT_WID'(fifo_pop_c);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (push_c) wr_ptr_d = (wr_ptr_q == PTR_WID'(FIFO_D - 1)) ? '0 : wr_ptr_q + PTR_WID'(1);
    if (fifo_pop_c) rd_ptr_d = (rd_ptr_q == PTR_WID'(FIFO_D - 1)) ? '0 : rd_ptr_q + PTR_WID'(1);
    inflight_c = SUM_WID'(rd_en_q);
    for (int k = 0; k < int'(RD_LAT) - 1; k++) inflight_c = inflight_c + SUM_WID'(ret_pipe_q[k]);
    credit_ok_c = (SUM_WID'(count_d) + inflight_c) < SUM_WID'(FIFO_D);
    ret_pipe_d  = {ret_pipe_q[RD_LAT-2:0], rd_en_q};
    tok_d       = shift_en_c ? {tok_q[SIZE-2:0], pop_c} : tok_q;
    for (int i = 0; i < int'(SIZE); i++) begin
      stage0_vld_d[i] = pop_c && (VN_WID'(i) < vnum_q);
      stage0_data_d[i*DATA_WID +: DATA_WID] =
        stage0_vld_d[i] ? pop_data_c[i*DATA_WID +: DATA_WID] : '0;
    end
  end

  // Control FSM: read issue in LOAD, completion detection in DRAIN.
  always_comb begin
    state_d   = state_q;
    n_words_d = n_words_q;
    issue_d   = issue_q;
    vnum_d    = vnum_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    err_d     = 1'b0;
    drained_c = (ret_pipe_d == '0) && (count_d == '0) && (tok_d == '0);
    unique case (state_q)
      ST_IDLE: begin
        if (feed_start_i) begin
          if (ksize_legal(kernel_size_i) && (valid_num_i != '0) &&
              (valid_num_i <= VN_WID'(SIZE))) begin
            n_words_d = ksize_sq(kernel_size_i);
            vnum_d    = valid_num_i;
            issue_d   = '0;
            state_d   = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (credit_ok_c) begin
          rd_en_d   = 1'b1;
          rd_addr_d = issue_q;
          issue_d   = issue_q + ADDR_WID'(1);
          if (issue_q == n_words_q - ADDR_WID'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (drained_c) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      n_words_q  <= '0;
      issue_q    <= '0;
      vnum_q     <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ret_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tok_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_words_q  <= n_words_d;
      issue_q    <= issue_d;
      vnum_q     <= vnum_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ret_pipe_q <= ret_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tok_q      <= tok_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(FIFO_D); k++) fifo_mem_q[k] <= '0;
    end else if (push_c) begin
      fifo_mem_q[wr_ptr_q] <= buf_rd_data_i;
    end
  end

  // Stage 0 is common to all lanes; lane i then adds i more stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage0_data_q <= '0;
      stage0_vld_q  <= '0;
    end else if (shift_en_c) begin
      stage0_data_q <= stage0_data_d;
      stage0_vld_q  <= stage0_vld_d;
    end
  end

  for (genvar g = 0; g < int'(SIZE); g++) begin : g_lane
    skew_line #(
      .DATA_WID (DATA_WID),
      .DEPTH    (g)
    ) u_skew (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (shift_en_c),
      .data_i  (stage0_data_q[g*DATA_WID +: DATA_WID]),
      .valid_i (stage0_vld_q[g]),
      .data_o  (arr_wgt_o[g*DATA_WID +: DATA_WID]),
      .valid_o (arr_wgt_valid_o[g])
    );
  end

  assign feed_ready_o  = ready_q;
  assign feed_done_o   = done_q;
  assign feed_err_o    = err_q;
  assign buf_rd_addr_o = rd_addr_q;
  assign buf_rd_en_o   = rd_en_q;

endmodule

// File: tb/tb_wgt_feeder.sv
// Directed bench for wgt_feeder: buffer model with 2-cycle latency, negedge monitor, cycle-exact checks.
module tb_wgt_feeder;
  import wgt_pkg::*;

  logic                clk;
  logic                rst;
  logic                fstart;
  logic [KS_WID-1:0]   ksize;
  logic [VN_WID-1:0]   vnum;
  logic                ready, done, err, rd_en, stall;
  logic [ADDR_WID-1:0] rd_addr;
  logic [WORD_WID-1:0] rd_data, bstage, wgt;
  logic [SIZE-1:0]     wvld;

  wgt_feeder dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .feed_start_i    (fstart),
    .kernel_size_i   (ksize),
    .valid_num_i     (vnum),
    .feed_ready_o    (ready),
    .feed_done_o     (done),
    .feed_err_o      (err),
    .buf_rd_addr_o   (rd_addr),
    .buf_rd_en_o     (rd_en),
    .buf_rd_data_i   (rd_data),
    .arr_stall_i     (stall),
    .arr_wgt_o       (wgt),
    .arr_wgt_valid_o (wvld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WORD_WID-1:0] word_of(input int k);
    logic [WORD_WID-1:0] w;
    for (int i = 0; i < int'(SIZE); i++) w[i*DATA_WID +: DATA_WID] = DATA_WID'(k + 256 * i);
    return w;
  endfunction

  // Kernel buffer: data valid two cycles after the read enable is seen.
  always @(posedge clk) begin
    if (rd_en) bstage <= word_of(int'(rd_addr));
    rd_data <= bstage;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    if (idx >= 0 && idx < q.size()) return q[idx];
    return -1;
  endfunction

  bit mon_en = 1'b0;
  int t0 = 0, n_cur = 1, vn_cur = 0, stall_lo = 1, stall_hi = 0;
  int rd_cyc[$], done_cyc[$], err_cyc[$];
  int lane_cnt[SIZE], lane_first[SIZE];
  int addr_bad, order_bad, mask_bad, frozen_bad, ready_low, outst, max_outst;
  int m_rel;
  logic m_sp;
  logic [WORD_WID-1:0] prev_wgt;
  logic [SIZE-1:0]     prev_vld;

  task automatic clear_mon();
    rd_cyc.delete(); done_cyc.delete(); err_cyc.delete();
    for (int i = 0; i < int'(SIZE); i++) begin lane_cnt[i] = 0; lane_first[i] = -1; end
    addr_bad = 0; order_bad = 0; mask_bad = 0; frozen_bad = 0;
    ready_low = 0; outst = 0; max_outst = 0;
  endtask

  // Monitor: samples on negedge, then drives the stall pattern for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      m_rel = cyc - t0;
      m_sp  = stall;
      if (rd_en) begin
        if (int'(rd_addr) != rd_cyc.size() % n_cur) addr_bad++;
        rd_cyc.push_back(m_rel);
        outst++;
      end
      for (int i = 0; i < int'(SIZE); i++) begin
        if (wvld[i] && !m_sp) begin
          if (int'(wgt[i*DATA_WID +: DATA_WID]) != (lane_cnt[i] % n_cur) + 256 * i) order_bad++;
          if (lane_cnt[i] == 0) lane_first[i] = m_rel;
          lane_cnt[i]++;
          if (i == 0) outst--;
        end
        if (i >= vn_cur && (wvld[i] || wgt[i*DATA_WID +: DATA_WID] != '0)) mask_bad++;
      end
      if (outst > max_outst) max_outst = outst;
      if (m_sp && (wgt != prev_wgt || wvld != prev_vld)) frozen_bad++;
      if (done) done_cyc.push_back(m_rel);
      if (err) err_cyc.push_back(m_rel);
      if (!ready) ready_low++;
      prev_wgt = wgt;
      prev_vld = wvld;
      stall = (m_rel >= stall_lo && m_rel <= stall_hi);
    end
  end

  task automatic start_run(input logic [KS_WID-1:0] ks, input logic [VN_WID-1:0] vn,
                           input int slo, input int shi, input int nexp, input bit hold);
    @(posedge clk); #1;
    clear_mon();
    n_cur = nexp; vn_cur = int'(vn); stall_lo = slo; stall_hi = shi;
    t0 = cyc + 1;
    ksize = ks; vnum = vn; fstart = 1'b1; mon_en = 1'b1;
    if (!hold) begin
      @(posedge clk); #1;
      fstart = 1'b0;
      ksize  = 3'd7;
      vnum   = 4'd0;
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cyc.size() < n && k < budget) begin @(posedge clk); k++; end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ready"}, int'(ready), 1);
    check_val({tag, "_done"},  int'(done), 0);
    check_val({tag, "_err"},   int'(err), 0);
    check_val({tag, "_rden"},  int'(rd_en), 0);
    check_val({tag, "_addr"},  int'(rd_addr), 0);
    check_val({tag, "_wgt_nz"}, int'(wgt != '0), 0);
    check_val({tag, "_vld"},   int'(wvld), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; fstart = 1'b0; ksize = '0; vnum = '0; stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // ksize 3, all lanes, no stall; ksize/valid_num scrambled after start
    start_run(3'd3, 4'd8, 1, 0, 9, 1'b0);
    wait_done(1, 200);
    check_val("k3_rd_n", rd_cyc.size(), 9);
    check_val("k3_rd_first", q_at(rd_cyc, 0), 1);
    check_val("k3_rd_last", q_at(rd_cyc, 8), 9);
    check_val("k3_addr_bad", addr_bad, 0);
    check_val("k3_lane0_first", lane_first[0], 4);
    check_val("k3_lane7_first", lane_first[7], 11);
    check_val("k3_lane0_n", lane_cnt[0], 9);
    check_val("k3_lane7_n", lane_cnt[7], 9);
    check_val("k3_order_bad", order_bad, 0);
    check_val("k3_done_n", done_cyc.size(), 1);
    check_val("k3_done_cyc", q_at(done_cyc, 0), 20);
    check_val("k3_max_outst", max_outst, 3);

    // ksize 1, three live lanes
    start_run(3'd1, 4'd3, 1, 0, 1, 1'b0);
    wait_done(1, 200);
    check_val("k1_rd_n", rd_cyc.size(), 1);
    check_val("k1_lane0_n", lane_cnt[0], 1);
    check_val("k1_lane2_n", lane_cnt[2], 1);
    check_val("k1_lane2_first", lane_first[2], 6);
    check_val("k1_lane3_n", lane_cnt[3], 0);
    check_val("k1_mask_bad", mask_bad, 0);
    check_val("k1_order_bad", order_bad, 0);
    check_val("k1_done_cyc", q_at(done_cyc, 0), 12);

    // ksize 5 with array stall in cycles 6..9
    start_run(3'd5, 4'd8, 6, 9, 25, 1'b0);
    wait_done(1, 300);
    check_val("k5_rd_n", rd_cyc.size(), 25);
    check_val("k5_addr_bad", addr_bad, 0);
    check_val("k5_frozen_bad", frozen_bad, 0);
    check_val("k5_order_bad", order_bad, 0);
    check_val("k5_lane7_n", lane_cnt[7], 25);
    check_val("k5_max_outst", max_outst, 3);
    check_val("k5_done_cyc", q_at(done_cyc, 0), 40);

    // illegal starts
    start_run(3'd2, 4'd8, 1, 0, 1, 1'b0);
    repeat (6) @(posedge clk);
    check_val("ks2_err_n", err_cyc.size(), 1);
    check_val("ks2_err_cyc", q_at(err_cyc, 0), 0);
    check_val("ks2_rd_n", rd_cyc.size(), 0);
    check_val("ks2_ready_low", ready_low, 0);
    start_run(3'd3, 4'd0, 1, 0, 1, 1'b0);
    repeat (6) @(posedge clk);
    check_val("vn0_err_n", err_cyc.size(), 1);
    check_val("vn0_rd_n", rd_cyc.size(), 0);
    check_val("vn0_ready_low", ready_low, 0);

    // reset in the middle of LOAD, then a fresh run
    start_run(3'd3, 4'd8, 1, 0, 9, 1'b0);
    mon_en = 1'b0;
    k = 0;
    while (!(rd_en && rd_addr == ADDR_WID'(4)) && k < 50) begin @(negedge clk); k++; end
    check_val("mid_hit_addr", rd_en ? int'(rd_addr) : -1, 4);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    start_run(3'd1, 4'd8, 1, 0, 1, 1'b0);
    wait_done(1, 200);
    check_val("post_rst_rd_n", rd_cyc.size(), 1);
    check_val("post_rst_done_cyc", q_at(done_cyc, 0), 12);

    // start held high: exactly one run, second begins on the feed_ready cycle
    start_run(3'd3, 4'd8, 1, 0, 9, 1'b1);
    do begin @(posedge clk); #1; end while (cyc - t0 < 22);
    fstart = 1'b0;
    wait_done(2, 200);
    check_val("hold_done_n", done_cyc.size(), 2);
    check_val("hold_done0_cyc", q_at(done_cyc, 0), 20);
    check_val("hold_rd_gap", q_at(rd_cyc, 9), 23);
    check_val("hold_done1_cyc", q_at(done_cyc, 1), 42);
    check_val("hold_rd_n", rd_cyc.size(), 18);
    check_val("hold_order_bad", order_bad, 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
